// File: rtl/dac_mon_pkg.sv
// Shared types and constants for the DAC SPI write-frame monitor.
package dac_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int FRAME_BITS_DFLT = 24;
    localparam int CNT_W           = 6;
    localparam int PD_W            = 2;
    localparam int ERR_W           = 8;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous level, with rise/fall strobes
// taken from the two oldest stages. RST_VAL sets the idle level after reset.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] r_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s <= {3{RST_VAL}};
        end else begin
            r_s <= {r_s[1:0], i_d};
        end
    end

    assign o_rise = (r_s[2:1] == 2'b01);
    assign o_fall = (r_s[2:1] == 2'b10);

endmodule

// File: rtl/dac_spi_monitor.sv
// Passive decoder for 24-bit DAC write frames on sclk/mosi/sync_n.
// Build option: define DAC_MON_ERRCNT_EN to enable the saturating bad-frame counter.
module dac_spi_monitor
    import dac_mon_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DFLT,
    parameter int DATA_BITS  = 16,
    parameter int PD_LSB     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 sync_n,
    output logic [DATA_BITS-1:0] dat,
    output logic [PD_W-1:0]      pd,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_cnt
);

    // Only the decoded low bits are retained; earlier frame bits fall off the top.
    localparam int SH_W = (PD_LSB + PD_W > DATA_BITS) ? PD_LSB + PD_W : DATA_BITS;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sync_rise;
    logic w_sync_fall;
    logic w_mosi;
    logic [2:0] r_mosi_s;

    sync_edge_det #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_sync_n_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (sync_n),
        .o_rise  (w_sync_rise),
        .o_fall  (w_sync_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mosi_s <= '0;
        end else begin
            r_mosi_s <= {r_mosi_s[1:0], mosi};
        end
    end

    assign w_mosi = r_mosi_s[2];

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [SH_W-1:0]        r_shreg, w_shreg_nxt;
    logic [DATA_BITS-1:0]   r_dat, w_dat_nxt;
    logic [PD_W-1:0]        r_pd, w_pd_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_err, w_err_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_dat_nxt   = r_dat;
        w_pd_nxt    = r_pd;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_sync_fall) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                end
            end
            SHIFT: begin
                // A final sclk fall coincident with the sync_n rise still counts.
                if (w_sclk_fall) begin
                    w_shreg_nxt = {r_shreg[SH_W-2:0], w_mosi};
                    w_cnt_nxt   = sat_inc_cnt(r_cnt);
                end
                if (w_sync_rise) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (r_cnt == CNT_W'(FRAME_BITS)) begin
                    w_dat_nxt   = r_shreg[DATA_BITS-1:0];
                    w_pd_nxt    = r_shreg[PD_LSB+PD_W-1:PD_LSB];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_dat   <= '0;
            r_pd    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_dat   <= w_dat_nxt;
            r_pd    <= w_pd_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign dat       = r_dat;
    assign pd        = r_pd;
    assign valid     = r_valid;
    assign frame_err = r_err;
    assign busy      = (r_state != IDLE);

`ifdef DAC_MON_ERRCNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    // sclk must stay high for several clk periods; a fall right after a rise means a glitch.
    a_sclk_high_time: assert property (@(posedge clk) disable iff (!reset_n)
        w_sclk_rise |=> !w_sclk_fall);

endmodule

// File: tb/tb_dac_spi_monitor.sv
// Self-checking bench for dac_spi_monitor: directed frames plus randomized
// frames scored against a frame-level reference model.
module tb_dac_spi_monitor;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk    = 1'b1;
    logic        mosi    = 1'b0;
    logic        sync_n  = 1'b1;
    logic [15:0] dat;
    logic [1:0]  pd;
    logic        valid;
    logic        frame_err;
    logic        busy;
    logic [7:0]  err_cnt;

    dac_spi_monitor dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .sync_n    (sync_n),
        .dat       (dat),
        .pd        (pd),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse counters, sampled just after each rising edge.
    int n_valid = 0;
    int n_err   = 0;
    always @(posedge clk) begin
        #1;
        if (valid)     n_valid++;
        if (frame_err) n_err++;
    end

    // Frame-level reference model.
    logic [15:0] m_dat   = '0;
    logic [1:0]  m_pd    = '0;
    int          m_err   = 0;
    int          m_valid = 0;
    int          m_errs  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_frame(input logic [63:0] bits, input int n);
        if (n == 24) begin
            m_dat = bits[15:0];
            m_pd  = bits[17:16];
            m_valid++;
        end else begin
            m_errs++;
`ifdef DAC_MON_ERRCNT_EN
            if (m_err < 255) m_err++;
`endif
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        sync_n = 1'b0;
        clks(2);
    endtask

    task automatic shift_bits(input logic [63:0] bits, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            clks(half);
            sclk = 1'b0;
            clks(half);
            sclk = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [63:0] bits, input int n, input int half, input int gap);
        start_frame();
        shift_bits(bits, n, half);
        clks(2);
        sync_n = 1'b1;
        clks(gap);
        model_frame(bits, n);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".dat"},     dat,       m_dat);
        check({tag, ".pd"},      pd,        m_pd);
        check({tag, ".nvalid"},  n_valid,   m_valid);
        check({tag, ".nerr"},    n_err,     m_errs);
        check({tag, ".err_cnt"}, err_cnt,   m_err);
        check({tag, ".busy"},    busy,      1'b0);
    endtask

    logic [63:0] fb;
    int          nb;
    int          half;

    initial begin
        // Reset state.
        clks(3);
        check("rst.dat",       dat,       16'h0);
        check("rst.pd",        pd,        2'b00);
        check("rst.valid",     valid,     1'b0);
        check("rst.frame_err", frame_err, 1'b0);
        check("rst.busy",      busy,      1'b0);
        check("rst.err_cnt",   err_cnt,   8'h0);
        reset_n = 1'b1;
        clks(3);

        // Good frame 7FFF, pd=00, with exact E+3 latency check.
        fb = {40'h0, 6'h2A, 2'b00, 16'h7FFF};
        start_frame();
        shift_bits(fb, 24, 4);
        check("t1.busy_mid", busy, 1'b1);
        clks(2);
        sync_n = 1'b1;
        clks(3);
        check("t1.valid_e2", valid, 1'b0);
        check("t1.busy_e2",  busy,  1'b1);
        clks(1);
        check("t1.valid_e3", valid, 1'b1);
        check("t1.dat_e3",   dat,   16'h7FFF);
        check("t1.busy_e3",  busy,  1'b0);
        clks(1);
        check("t1.valid_e4", valid, 1'b0);
        clks(4);
        model_frame(fb, 24);
        check_state("t1");

        // Back-to-back frames with 3-clk sync_n high gaps.
        do_frame({40'h0, 6'h00, 2'b00, 16'h0000}, 24, 4, 3);
        do_frame({40'h0, 6'h3F, 2'b11, 16'hFFFF}, 24, 4, 6);
        check_state("t2");

        // Short frame after a good one.
        do_frame({40'h0, 6'h11, 2'b01, 16'h1234}, 24, 4, 6);
        do_frame(64'h55_AAAA, 23, 4, 6);
        check_state("t3");

        // Over-long frame, then an empty sync_n pulse.
        do_frame(64'h2ABC_DEF1, 30, 3, 6);
        do_frame(64'h0, 0, 3, 6);
        check_state("t4");

        // Final sclk fall coincident with the sync_n rise.
        fb = {40'h0, 6'h05, 2'b10, 16'h5A3C};
        start_frame();
        shift_bits(fb >> 1, 23, 4);
        mosi = fb[0];
        clks(4);
        sclk   = 1'b0;
        sync_n = 1'b1;
        clks(4);
        sclk = 1'b1;
        clks(4);
        model_frame(fb, 24);
        check_state("t5");

        // Reset in the middle of a frame; the master abandons the frame too.
        start_frame();
        shift_bits(64'hFF_FFFF, 12, 4);
        reset_n = 1'b0;
        sync_n  = 1'b1;
        clks(2);
        m_dat = '0;
        m_pd  = '0;
        m_err = 0;
        check_state("t6.rst");
        check("t6.valid", valid,     1'b0);
        check("t6.ferr",  frame_err, 1'b0);
        reset_n = 1'b1;
        clks(8);
        check_state("t6.post");
        do_frame({40'h0, 6'h00, 2'b01, 16'hABCD}, 24, 4, 6);
        check_state("t6.next");

        // Randomized frames, mostly well-formed.
        for (int k = 0; k < 24; k++) begin
            fb   = {$urandom, $urandom};
            nb   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : 24;
            half = $urandom_range(3, 6);
            do_frame(fb, nb, half, 6);
            check_state($sformatf("rnd%0d", k));
        end

        // sclk activity with sync_n high is ignored.
        for (int k = 0; k < 10; k++) begin
            mosi = k[0];
            clks(4);
            sclk = 1'b0;
            clks(4);
            sclk = 1'b1;
        end
        clks(4);
        check_state("t7.idle_sclk");

        // Many bad frames drive err_cnt into saturation.
        for (int k = 0; k < 300; k++) begin
            do_frame(64'h0, 0, 3, 4);
        end
        clks(4);
        check_state("t8.sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
